// File: rtl/wb_arbiter.sv
// Writeback arbiter: two 2-entry source queues drained round-robin into the reg_file write port,
// plus a per-register busy scoreboard. Define WB_BYPASS_EN to forward the retiring value to queries.

module wb_arbiter_q #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  nonempty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data
);
    logic [ADDR_WIDTH-1:0] addr_mem [2];
    logic [DATA_WIDTH-1:0] data_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            cnt;
    logic                  push;

    // Ready comes from the registered count only, so a same-cycle pop never frees a full slot.
    assign push_ready = (cnt != 2'd2);
    assign push       = push_valid & push_ready;
    assign nonempty   = (cnt != 2'd0);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic                  alloc_valid,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  alloc_ready,
    input  logic [ADDR_WIDTH-1:0] q0_addr,
    input  logic [ADDR_WIDTH-1:0] q1_addr,
    output logic                  q0_busy,
    output logic                  q1_busy,
    output logic                  q0_fwd_valid,
    output logic                  q1_fwd_valid,
    output logic [DATA_WIDTH-1:0] q0_fwd_data,
    output logic [DATA_WIDTH-1:0] q1_fwd_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  err
);
    localparam int NREG = 1 << ADDR_WIDTH;

    // Handshakes: a transfer happens in any cycle where valid and ready are both high at the clock
    // edge; ready never depends on valid, and alloc_ready is a pure function of registered busy state.
    logic                  ne0, ne1, pop0, pop1;
    logic [ADDR_WIDTH-1:0] h0_addr, h1_addr, head_addr;
    logic [DATA_WIDTH-1:0] h0_data, h1_data, head_data;
    logic                  rr;
    logic                  any;
    logic                  pick;
    logic [NREG-1:0]       busy;
    logic                  alloc_take;

    wb_arbiter_q #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_q0 (
        .clk(clk), .rst(rst), .push_valid(s0_valid), .push_ready(s0_ready),
        .push_addr(s0_addr), .push_data(s0_data), .pop(pop0), .nonempty(ne0),
        .head_addr(h0_addr), .head_data(h0_data)
    );

    wb_arbiter_q #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_q1 (
        .clk(clk), .rst(rst), .push_valid(s1_valid), .push_ready(s1_ready),
        .push_addr(s1_addr), .push_data(s1_data), .pop(pop1), .nonempty(ne1),
        .head_addr(h1_addr), .head_data(h1_data)
    );

    // rr holds the last winner; on contention the other source goes.
    always_comb begin
        any  = ne0 | ne1;
        pick = 1'b0;
        if (ne0 && ne1) begin
            pick = ~rr;
        end else if (ne1) begin
            pick = 1'b1;
        end
    end

    assign pop0      = any & ~pick;
    assign pop1      = any & pick;
    assign head_addr = pick ? h1_addr : h0_addr;
    assign head_data = pick ? h1_data : h0_data;
    assign wen       = any && (head_addr != '0);
    assign waddr     = head_addr;
    assign wdata     = head_data;

    assign alloc_ready = (alloc_addr == '0) || !busy[alloc_addr];
    assign alloc_take  = alloc_valid && (alloc_addr != '0) && !busy[alloc_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b1;
        end else if (any) begin
            rr <= pick;
        end
    end

    // An accepted alloc is ordered after the retire clear, so it wins on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            if (wen) begin
                busy[waddr] <= 1'b0;
                if (!busy[waddr]) begin
                    err <= 1'b1;
                end
            end
            if (alloc_take) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    // busy[0] is never set, so r0 queries read as free without a special case.
    always_comb begin
`ifdef WB_BYPASS_EN
        q0_fwd_valid = wen && (q0_addr == waddr);
        q1_fwd_valid = wen && (q1_addr == waddr);
        q0_busy      = busy[q0_addr] && !q0_fwd_valid;
        q1_busy      = busy[q1_addr] && !q1_fwd_valid;
        q0_fwd_data  = q0_fwd_valid ? wdata : '0;
        q1_fwd_data  = q1_fwd_valid ? wdata : '0;
`else
        q0_fwd_valid = 1'b0;
        q1_fwd_valid = 1'b0;
        q0_busy      = busy[q0_addr];
        q1_busy      = busy[q1_addr];
        q0_fwd_data  = '0;
        q1_fwd_data  = '0;
`endif
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, alternation sequence,
// then randomized traffic against a queue-based reference model.

module tb_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam bit NB = !BYP;

    logic          clk;
    logic          rst;
    logic          s0_valid, s1_valid, alloc_valid;
    logic          s0_ready, s1_ready, alloc_ready;
    logic [AW-1:0] s0_addr, s1_addr, alloc_addr, q0_addr, q1_addr, waddr;
    logic [DW-1:0] s0_data, s1_data, q0_fwd_data, q1_fwd_data, wdata;
    logic          q0_busy, q1_busy, q0_fwd_valid, q1_fwd_valid, wen, err;

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
        .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_busy(q0_busy), .q1_busy(q1_busy),
        .q0_fwd_valid(q0_fwd_valid), .q1_fwd_valid(q1_fwd_valid),
        .q0_fwd_data(q0_fwd_data), .q1_fwd_data(q1_fwd_data),
        .wen(wen), .waddr(waddr), .wdata(wdata), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW+DW-1:0] exp_q0[$];
    logic [AW+DW-1:0] exp_q1[$];
    bit               m_last;          // source that won most recently
    bit               m_busy[1<<AW];
    bit               m_err;
    bit               e_any, e_pick, e_wen, e_s0r, e_s1r, e_ar, e_b0, e_b1, e_f0, e_f1;
    logic [AW-1:0]    e_waddr;
    logic [DW-1:0]    e_wdata;

    task automatic model_clear();
        exp_q0.delete();
        exp_q1.delete();
        m_last = 1'b1;
        m_err  = 1'b0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    task automatic model_eval();
        logic [AW+DW-1:0] head;
        bit h0, h1;
        h0 = exp_q0.size() > 0;
        h1 = exp_q1.size() > 0;
        e_any  = h0 || h1;
        e_pick = (h0 && h1) ? !m_last : h1;
        head   = '0;
        if (e_any) head = e_pick ? exp_q1[0] : exp_q0[0];
        e_waddr = head[AW+DW-1:DW];
        e_wdata = head[DW-1:0];
        e_wen   = e_any && (e_waddr != 0);
        e_s0r   = exp_q0.size() < 2;
        e_s1r   = exp_q1.size() < 2;
        e_ar    = (alloc_addr == 0) || !m_busy[alloc_addr];
        e_f0    = BYP && e_wen && (q0_addr == e_waddr);
        e_f1    = BYP && e_wen && (q1_addr == e_waddr);
        e_b0    = (q0_addr != 0) && m_busy[q0_addr] && !e_f0;
        e_b1    = (q1_addr != 0) && m_busy[q1_addr] && !e_f1;
    endtask

    task automatic model_commit();
        bit take0, take1, take_alloc;
        take0      = s0_valid && exp_q0.size() < 2;
        take1      = s1_valid && exp_q1.size() < 2;
        take_alloc = alloc_valid && (alloc_addr != 0) && !m_busy[alloc_addr];
        if (e_any) begin
            if (e_pick) void'(exp_q1.pop_front());
            else        void'(exp_q0.pop_front());
            m_last = e_pick;
        end
        if (take0) exp_q0.push_back({s0_addr, s0_data});
        if (take1) exp_q1.push_back({s1_addr, s1_data});
        if (e_wen) begin
            if (!m_busy[e_waddr]) m_err = 1'b1;
            m_busy[e_waddr] = 1'b0;
        end
        if (take_alloc) m_busy[alloc_addr] = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " s0_ready"}, s0_ready, e_s0r);
        chk({tag, " s1_ready"}, s1_ready, e_s1r);
        chk({tag, " alloc_ready"}, alloc_ready, e_ar);
        chk({tag, " wen"}, wen, e_wen);
        if (e_wen) begin
            chk({tag, " waddr"}, waddr, e_waddr);
            chk({tag, " wdata"}, wdata, e_wdata);
        end
        chk({tag, " q0_busy"}, q0_busy, e_b0);
        chk({tag, " q1_busy"}, q1_busy, e_b1);
        chk({tag, " q0_fwd_valid"}, q0_fwd_valid, e_f0);
        chk({tag, " q1_fwd_valid"}, q1_fwd_valid, e_f1);
        if (e_f0 || !BYP) chk({tag, " q0_fwd_data"}, q0_fwd_data, e_f0 ? e_wdata : '0);
        if (e_f1 || !BYP) chk({tag, " q1_fwd_data"}, q1_fwd_data, e_f1 ? e_wdata : '0);
        chk({tag, " err"}, err, m_err);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        s0_valid = 0; s0_addr = '0; s0_data = '0;
        s1_valid = 0; s1_addr = '0; s1_data = '0;
        alloc_valid = 0; alloc_addr = '0; q0_addr = '0; q1_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic step_model(input string tag);
        #1;
        model_eval();
        check_model(tag);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic s0v; logic [AW-1:0] s0a; logic [DW-1:0] s0d;
        logic s1v; logic [AW-1:0] s1a; logic [DW-1:0] s1d;
        logic av;  logic [AW-1:0] aa;  logic [AW-1:0] qa0; logic [AW-1:0] qa1;
        logic e_wen; logic [AW-1:0] e_waddr; logic [DW-1:0] e_wdata;
        logic e_s0r, e_s1r, e_ar, e_b0, e_b1, e_f1v, e_err;
    } vec_t;

    function automatic vec_t v(input logic s0v, input int s0a, input logic [DW-1:0] s0d,
                               input logic s1v, input int s1a, input logic [DW-1:0] s1d,
                               input logic av, input int aa, input int qa0, input int qa1,
                               input logic w, input int wa, input logic [DW-1:0] wd,
                               input logic r0, input logic r1, input logic ar,
                               input logic b0, input logic b1, input logic f1, input logic er);
        vec_t t;
        t.s0v = s0v; t.s0a = AW'(s0a); t.s0d = s0d;
        t.s1v = s1v; t.s1a = AW'(s1a); t.s1d = s1d;
        t.av = av; t.aa = AW'(aa); t.qa0 = AW'(qa0); t.qa1 = AW'(qa1);
        t.e_wen = w; t.e_waddr = AW'(wa); t.e_wdata = wd;
        t.e_s0r = r0; t.e_s1r = r1; t.e_ar = ar; t.e_b0 = b0; t.e_b1 = b1; t.e_f1v = f1; t.e_err = er;
        return t;
    endfunction

    vec_t tbl[18];

    initial begin
        int n_writes;
        bit exp_src;

        tbl[0]  = v(0, 0, 0,            0, 0, 0,       0, 0, 3, 5,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[1]  = v(0, 0, 0,            0, 0, 0,       1, 3, 3, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[2]  = v(1, 3, 32'h1111_1111, 0, 0, 0,      0, 0, 3, 0,  0, 0, 0,            1, 1, 1, 1,  0,  0,   0);
        tbl[3]  = v(0, 0, 0,            0, 0, 0,       0, 0, 3, 0,  1, 3, 32'h1111_1111, 1, 1, 1, NB, 0,  0,   0);
        tbl[4]  = v(0, 0, 0,            0, 0, 0,       0, 0, 3, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[5]  = v(0, 0, 0,            0, 0, 0,       1, 5, 5, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[6]  = v(0, 0, 0,            1, 5, 32'h55,  1, 5, 5, 0,  0, 0, 0,            1, 1, 0, 1,  0,  0,   0);
        tbl[7]  = v(0, 0, 0,            0, 0, 0,       1, 5, 5, 5,  1, 5, 32'h55,       1, 1, 0, NB, NB, BYP, 0);
        tbl[8]  = v(0, 0, 0,            0, 0, 0,       0, 5, 5, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[9]  = v(1, 0, 32'hDEAD,     0, 0, 0,       1, 0, 0, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[10] = v(0, 0, 0,            0, 0, 0,       0, 0, 0, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[11] = v(1, 7, 32'h77,       0, 0, 0,       0, 0, 7, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   0);
        tbl[12] = v(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  1, 7, 32'h77,       1, 1, 1, 0,  0,  0,   0);
        tbl[13] = v(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  0, 0, 0,            1, 1, 1, 0,  0,  0,   1);
        tbl[14] = v(0, 0, 0,            0, 0, 0,       1, 9, 0, 9,  0, 0, 0,            1, 1, 1, 0,  0,  0,   1);
        tbl[15] = v(0, 0, 0,            1, 9, 32'h42,  0, 0, 0, 9,  0, 0, 0,            1, 1, 1, 0,  1,  0,   1);
        tbl[16] = v(0, 0, 0,            0, 0, 0,       0, 0, 0, 9,  1, 9, 32'h42,       1, 1, 1, 0,  NB, BYP, 1);
        tbl[17] = v(0, 0, 0,            0, 0, 0,       0, 0, 0, 9,  0, 0, 0,            1, 1, 1, 0,  0,  0,   1);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            s0_valid = tbl[i].s0v; s0_addr = tbl[i].s0a; s0_data = tbl[i].s0d;
            s1_valid = tbl[i].s1v; s1_addr = tbl[i].s1a; s1_data = tbl[i].s1d;
            alloc_valid = tbl[i].av; alloc_addr = tbl[i].aa;
            q0_addr = tbl[i].qa0; q1_addr = tbl[i].qa1;
            #1;
            chk($sformatf("row%0d wen", i), wen, tbl[i].e_wen);
            if (tbl[i].e_wen) begin
                chk($sformatf("row%0d waddr", i), waddr, tbl[i].e_waddr);
                chk($sformatf("row%0d wdata", i), wdata, tbl[i].e_wdata);
            end
            chk($sformatf("row%0d s0_ready", i), s0_ready, tbl[i].e_s0r);
            chk($sformatf("row%0d s1_ready", i), s1_ready, tbl[i].e_s1r);
            chk($sformatf("row%0d alloc_ready", i), alloc_ready, tbl[i].e_ar);
            chk($sformatf("row%0d q0_busy", i), q0_busy, tbl[i].e_b0);
            chk($sformatf("row%0d q1_busy", i), q1_busy, tbl[i].e_b1);
            chk($sformatf("row%0d q1_fwd_valid", i), q1_fwd_valid, tbl[i].e_f1v);
            if (tbl[i].e_f1v) chk($sformatf("row%0d q1_fwd_data", i), q1_fwd_data, tbl[i].e_wdata);
            if (!BYP) chk($sformatf("row%0d q1_fwd_data_zero", i), q1_fwd_data, '0);
            chk($sformatf("row%0d err", i), err, tbl[i].e_err);
            @(posedge clk);
            #1;
        end

        // Both sources streaming: writes must alternate starting with src0.
        do_reset();
        n_writes = 0;
        exp_src  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            s0_valid = 1; s0_addr = 10; s0_data = {1'b0, 31'(i)};
            s1_valid = 1; s1_addr = 11; s1_data = {1'b1, 31'(i)};
            #1;
            if (wen) begin
                chk($sformatf("alt write%0d source", n_writes), wdata[31], exp_src);
                exp_src = !exp_src;
                n_writes++;
            end
            step_model($sformatf("alt cyc%0d", i));
        end
        chk("alt write count", n_writes >= 12, 1'b1);

        // Randomized traffic with a reset at each segment start, often mid-stream.
        for (int seg = 0; seg < 10; seg++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                s0_valid    = $urandom_range(0, 99) < 60;
                s0_addr     = AW'($urandom_range(0, 7));
                s0_data     = $urandom;
                s1_valid    = $urandom_range(0, 99) < 50;
                s1_addr     = AW'($urandom_range(0, 7));
                s1_data     = $urandom;
                alloc_valid = $urandom_range(0, 99) < 50;
                alloc_addr  = AW'($urandom_range(0, 7));
                q0_addr     = AW'($urandom_range(0, 7));
                q1_addr     = AW'($urandom_range(0, 7));
                step_model($sformatf("rnd s%0d c%0d", seg, c));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
